// File: rtl/sa_pkg.sv
// Shared state encoding and default sizes for the systolic-array host interface.
package sa_pkg;

  localparam int SA_ROWS     = 8;
  localparam int SA_INWIDTH  = 8;
  localparam int SA_OUTWIDTH = 32;
  localparam int SA_LENW     = 16;

  typedef enum logic [2:0] {
    IDLE,
    FEED,
    WAIT_RES,
    DRAIN,
    ACK
  } sa_state_e;

endpackage

// File: rtl/sa_result_serializer.sv
// Captures one result set and streams it column 0..ROWS-1; first word one cycle after capture.
// res_data/res_col/res_last hold while res_ready is low; set_done marks the last word's handshake.
module sa_result_serializer #(
  parameter int ROWS     = 8,
  parameter int OUTWIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           capture,
  input  logic                           start,
  input  logic                           last_set,
  input  logic [ROWS-1:0][OUTWIDTH-1:0]  routport,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [OUTWIDTH-1:0]            res_data,
  output logic [$clog2(ROWS)-1:0]        res_col,
  output logic                           res_last,
  output logic                           set_done
);

  localparam int CW = $clog2(ROWS);
  localparam logic [CW-1:0] LAST_COL = CW'(ROWS - 1);

  logic [ROWS-1:0][OUTWIDTH-1:0] cap_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cap_q     <= '0;
      res_valid <= 1'b0;
      res_col   <= '0;
    end else begin
      if (capture) cap_q <= routport;
      if (start) begin
        res_valid <= 1'b1;
        res_col   <= '0;
      end else if (res_valid && res_ready) begin
        if (res_col == LAST_COL) res_valid <= 1'b0;
        else                     res_col   <= res_col + CW'(1);
      end
    end
  end

  assign res_data = cap_q[res_col];
  assign res_last = res_valid && last_set && (res_col == LAST_COL);
  assign set_done = res_valid && res_ready && (res_col == LAST_COL);

endmodule

// File: rtl/sa_host_if.sv
// Host front end for a ROWSxROWS systolic core: feeds K operand beats (inpvalid one cycle after
// each beat), then drains ROWS result sets; operand and result streams are valid/ready.
module sa_host_if
  import sa_pkg::*;
#(
  parameter int ROWS     = SA_ROWS,
  parameter int INWIDTH  = SA_INWIDTH,
  parameter int OUTWIDTH = SA_OUTWIDTH,
  parameter int LENW     = SA_LENW
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [LENW-1:0]                cmd_len,
  input  logic                           src_valid,
  output logic                           src_ready,
  input  logic [ROWS*INWIDTH-1:0]        src_a,
  input  logic [ROWS*INWIDTH-1:0]        src_w,
  output logic                           inpvalid,
  output logic [ROWS-1:0][INWIDTH-1:0]   ainport,
  output logic [ROWS-1:0][INWIDTH-1:0]   winport,
  input  logic [ROWS-1:0][OUTWIDTH-1:0]  routport,
  input  logic [ROWS-1:0]                rvalidport,
  output logic                           outread,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [OUTWIDTH-1:0]            res_data,
  output logic [$clog2(ROWS)-1:0]        res_col,
  output logic                           res_last,
  output logic                           busy,
  output logic                           done
);

  localparam int SW = $clog2(ROWS + 1);
  localparam logic [SW-1:0] ROWS_S = SW'(ROWS);

  sa_state_e        state, state_nxt;
  logic [LENW-1:0]  len_q;
  logic [LENW-1:0]  beat_cnt;
  logic [SW-1:0]    set_cnt;
  logic             capture, start, set_done;
  logic             outread_nxt, done_nxt;

  always_comb begin
    state_nxt   = state;
    cmd_ready   = 1'b0;
    src_ready   = 1'b0;
    capture     = 1'b0;
    start       = 1'b0;
    outread_nxt = 1'b0;
    done_nxt    = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_len != '0) state_nxt = FEED;
          else               done_nxt  = 1'b1;
        end
      end
      FEED: begin
        src_ready = 1'b1;
        if (src_valid && (beat_cnt + LENW'(1) == len_q)) state_nxt = WAIT_RES;
      end
      WAIT_RES: begin
        // Only a complete set is captured; partial valids keep us waiting.
        if (&rvalidport) begin
          capture   = 1'b1;
          start     = 1'b1;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (set_done) begin
          outread_nxt = 1'b1;
          state_nxt   = ACK;
        end
      end
      ACK: begin
        if (set_cnt < ROWS_S) begin
          state_nxt = WAIT_RES;
        end else begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      len_q    <= '0;
      beat_cnt <= '0;
      set_cnt  <= '0;
      inpvalid <= 1'b0;
      ainport  <= '0;
      winport  <= '0;
      outread  <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      inpvalid <= 1'b0;
      outread  <= outread_nxt;
      done     <= done_nxt;
      if (state == IDLE && cmd_valid) begin
        len_q    <= cmd_len;
        beat_cnt <= '0;
        set_cnt  <= '0;
      end
      if (state == FEED && src_valid) begin
        inpvalid <= 1'b1;
        ainport  <= src_a;
        winport  <= src_w;
        beat_cnt <= beat_cnt + LENW'(1);
      end
      if (state == DRAIN && set_done) set_cnt <= set_cnt + SW'(1);
    end
  end

  assign busy = (state != IDLE);

  sa_result_serializer #(
    .ROWS     (ROWS),
    .OUTWIDTH (OUTWIDTH)
  ) u_ser (
    .clk       (clk),
    .rstn      (rstn),
    .capture   (capture),
    .start     (start),
    .last_set  (set_cnt == SW'(ROWS - 1)),
    .routport  (routport),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_col   (res_col),
    .res_last  (res_last),
    .set_done  (set_done)
  );

endmodule

// File: doc/sa_host_if.md
SA_HOST_IF -- requirements
Module: sa_host_if

Interface
REQ-001 Parameters: ROWS, 8, array rows and columns (square array); INWIDTH, 8, operand width; OUTWIDTH, 32, result width; LENW, 16, command length width.
REQ-002 Clock and reset: one clock `clk`; reset `rstn` is synchronous and active-low.
REQ-003 Port list (name  direction  width  meaning):
- clk  in  1  clock
- rstn  in  1  sync active-low reset
- cmd_valid  in  1  job request
- cmd_ready  out  1  job accepted when high with cmd_valid
- cmd_len  in  LENW  operand beats K in the job
- src_valid  in  1  operand beat present
- src_ready  out  1  operand beat taken
- src_a  in  ROWS*INWIDTH  A beat; row i at bits [i*INWIDTH +: INWIDTH]
- src_w  in  ROWS*INWIDTH  W beat; same packing as src_a
- inpvalid  out  1  core input strobe
- ainport  out  INWIDTH x ROWS  A operands to the core
- winport  out  INWIDTH x ROWS  W operands to the core
- routport  in  OUTWIDTH x ROWS  core result, one per column
- rvalidport  in  1 x ROWS  per-column result valid
- outread  out  1  one-cycle pulse; releases the current result set
- res_valid  out  1  result word present
- res_ready  in  1  result word taken
- res_data  out  OUTWIDTH  result word
- res_col  out  clog2(ROWS)  column index of res_data
- res_last  out  1  final word of the job
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job end

Function
REQ-004 FSM states: IDLE, FEED, WAIT_RES, DRAIN, ACK.
REQ-005 IDLE: cmd_ready=1. On cmd_valid, latch cmd_len and clear the beat and set counters. Go to FEED if len>0. If len==0, pulse done in the next cycle and stay in IDLE.
REQ-006 FEED: src_ready=1 and cmd_ready=0.
- Each src_valid&&src_ready beat drives inpvalid=1 in the next cycle, with ainport/winport registered from src_a/src_w.
- In any cycle with no beat, inpvalid=0 and the beat counter holds.
REQ-007 After the K-th beat is accepted, go to WAIT_RES. src_ready drops in the cycle after the K-th beat; no extra beat is accepted.
REQ-008 The core has no input backpressure. inpvalid is never asserted outside FEED+1 timing.
REQ-009 WAIT_RES: wait until all rvalidport bits are 1.
- In that cycle, capture all ROWS routport words into a capture register and go to DRAIN.
- If only some bits are 1, keep waiting.
REQ-010 DRAIN: present the captured words in order, col 0 to ROWS-1, on the res stream with valid/ready semantics.
- res_data, res_col and res_last stay stable while res_valid=1 and res_ready=0.
REQ-011 After the column ROWS-1 word is accepted:
- pulse outread for exactly one cycle;
- increment the set counter;
- enter ACK.
REQ-012 ACK lasts one cycle so the core can update rvalidport.
- If set counter < ROWS, go to WAIT_RES.
- Otherwise pulse done, deassert busy and go to IDLE.
REQ-013 A job emits exactly ROWS*ROWS result words. res_last=1 only on set ROWS-1, column ROWS-1.
REQ-014 busy=1 in every state except IDLE. cmd_valid while busy is ignored (cmd_ready=0).
REQ-015 rvalidport changing during DRAIN has no effect; captured data is authoritative.

Reset
REQ-016 When rstn=0 at a clock edge, from any state:
- go to IDLE and clear the beat and set counters;
- drive to zero: inpvalid, outread, res_valid, res_last, done, busy, src_ready, ainport, winport, capture regs;
- cmd_ready=1 from the first cycle after reset is released.
REQ-017 A reset mid-job abandons the job. No outread and no done is issued for it.

Structure
REQ-018 Shared package sa_pkg holds:
- the state enum (IDLE, FEED, WAIT_RES, DRAIN, ACK);
- the default ROWS, INWIDTH, OUTWIDTH and LENW constants.
REQ-019 One sub-module, sa_result_serializer, holds the capture register, the column counter and the res_* handshake. It is driven by capture and start strobes from the main FSM and returns a set_done strobe.

Verification
REQ-020 ROWS=4, cmd_len=3, src_valid held high, A row i = i+1, W = 2 -> inpvalid high for exactly 3 consecutive cycles, starting 1 cycle after each accepted beat, with ainport matching.
REQ-021 cmd_len=0 -> cmd_ready stays 1, done pulses once, no inpvalid, no res_valid.
REQ-022 cmd_len=5 with src_valid toggling 1,0,1,0,... -> exactly 5 inpvalid cycles and no duplicated beat.
REQ-023 Core model raises rvalidport bits at cycles 2, 5, 9 for cols 0..2, and col 3 at cycle 12 -> capture occurs in cycle 12 only. Then 4 res words for cols 0..3, then one outread pulse.
REQ-024 res_ready low for 3 cycles mid-set -> res_data and res_col held. Full job yields 16 words; res_last only on the 16th; done one cycle after the final ACK.
REQ-025 rstn=0 during DRAIN of set 2 -> next cycle all outputs are zero and cmd_ready=1. A new job of len=2 then completes normally.
